// File: rtl/prmcu_uart_pkg.sv
// prmcu_uart_pkg: shared UART state encoding, frame limits and config clamp helper.
package prmcu_uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
    localparam int unsigned MIN_DATA_BITS = 5;
    localparam int unsigned MAX_DATA_BITS = 9;
    localparam int unsigned MIN_DIV = 2;
    function automatic int unsigned clamp(int unsigned v, int unsigned lo, int unsigned hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction
endpackage

// File: rtl/prmcu_uart_rx_if.sv
// prmcu_uart_rx_if: valid/ready output port of the UART receiver.
interface prmcu_uart_rx_if;
    logic [8:0] out_dat_o;
    logic       out_vld_o;
    logic       out_rdy_i;
    modport master (output out_dat_o, out_vld_o, input out_rdy_i);
    modport slave (input out_dat_o, out_vld_o, output out_rdy_i);
endinterface

// File: rtl/prmcu_uart_rx_fifo.sv
// prmcu_uart_rx_fifo: sync FIFO with valid/ready read side; a read frees a slot for a same-cycle write.
module prmcu_uart_rx_fifo #(
    parameter int W = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    output logic [W-1:0] rd_dat,
    output logic         rd_vld,
    input  logic         rd_rdy
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         rd, wr;
    assign rd_vld = wp != rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd = rd_vld & rd_rdy;
    assign wr = wr_en & (~full | rd);
    assign rd_dat = rd_vld ? mem[rp[AW-1:0]] : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr) begin
                mem[wp[AW-1:0]] <= wr_dat;
                wp <= wp + 1'b1;
            end
            if (rd) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/prmcu_uart_rx.sv
// prmcu_uart_rx: UART receiver, start/5..9 data/opt. even parity/1..2 stop, valid/ready output.
// Define PRMCU_UART_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO instead of a single holding register.
module prmcu_uart_rx
    import prmcu_uart_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_en,
    input  logic             rx_en,
    input  logic             n_parity_bits,
    input  logic [1:0]       n_stop_bits,
    input  logic [3:0]       n_data_bits,
    input  logic [DIV_W-1:0] internal_clk_divider,
    input  logic             rx_i,
    prmcu_uart_rx_if.master  out_if,
    output logic             parity_err_o,
    output logic             frame_err_o,
    output logic             overrun_o
);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end
    uart_state_t      state, state_n;
    logic             rx_m, rx_s, rx_prev;
    logic [DIV_W-1:0] baud_cnt, baud_n, div_l, div_n;
    logic [3:0]       bit_cnt, bit_n, nd_l, nd_n;
    logic [1:0]       ns_l, ns_n;
    logic             pen_l, pen_n;
    logic [8:0]       shreg, sh_n, word;
    logic             par_err, par_n, frm_err, frm_n;
    logic             en, start_edge, tick_mid, tick_end, last, good, accept;
    assign en = uart_en & rx_en;
    assign start_edge = rx_prev & ~rx_s;
    assign tick_mid = baud_cnt == (div_l >> 1);
    assign tick_end = baud_cnt == div_l - 1'b1;
    assign word = shreg >> (4'd9 - nd_l);
    assign good = last & ~frm_n & ~par_err;
    always_comb begin
        state_n = state;
        baud_n = baud_cnt + 1'b1;
        bit_n = bit_cnt;
        sh_n = shreg;
        par_n = par_err;
        frm_n = frm_err;
        div_n = div_l;
        nd_n = nd_l;
        ns_n = ns_l;
        pen_n = pen_l;
        last = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (start_edge) begin
                    state_n = START;
                    bit_n = '0;
                    sh_n = '0;
                    par_n = 1'b0;
                    frm_n = 1'b0;
                    div_n = DIV_W'(clamp(32'(internal_clk_divider), MIN_DIV, 2 ** DIV_W - 1));
                    nd_n = 4'(clamp(32'(n_data_bits), MIN_DATA_BITS, MAX_DATA_BITS));
                    ns_n = 2'(clamp(32'(n_stop_bits), 1, 2));
                    pen_n = n_parity_bits;
                end
            end
            START: if (tick_mid) begin
                baud_n = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (tick_end) begin
                baud_n = '0;
                sh_n = {rx_s, shreg[8:1]};
                bit_n = bit_cnt + 1'b1;
                if (bit_cnt == nd_l - 4'd1) begin
                    bit_n = '0;
                    state_n = pen_l ? PARITY : STOP;
                end
            end
            PARITY: if (tick_end) begin
                baud_n = '0;
                par_n = ^shreg ^ rx_s;
                state_n = STOP;
            end
            STOP: if (tick_end) begin
                baud_n = '0;
                frm_n = frm_err | ~rx_s;
                bit_n = bit_cnt + 1'b1;
                if (bit_cnt == 4'(ns_l) - 4'd1) begin
                    state_n = IDLE;
                    last = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!en) begin
            state_n = IDLE;
            last = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_m, rx_s, rx_prev} <= 3'b111;
            state <= IDLE;
            baud_cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            div_l <= DIV_W'(MIN_DIV);
            nd_l <= 4'(MIN_DATA_BITS);
            ns_l <= 2'd1;
            pen_l <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            {rx_m, rx_s, rx_prev} <= {rx_i, rx_m, rx_s};
            state <= state_n;
            baud_cnt <= baud_n;
            bit_cnt <= bit_n;
            shreg <= sh_n;
            par_err <= par_n;
            frm_err <= frm_n;
            div_l <= div_n;
            nd_l <= nd_n;
            ns_l <= ns_n;
            pen_l <= pen_n;
            frame_err_o <= last & frm_n;
            parity_err_o <= last & ~frm_n & par_err;
            overrun_o <= good & ~accept;
        end
    end
`ifdef PRMCU_UART_RX_FIFO_EN
    logic full;
    assign accept = ~full | (out_if.out_vld_o & out_if.out_rdy_i);
    prmcu_uart_rx_fifo #(.W(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (good & accept),
        .wr_dat (word),
        .full   (full),
        .rd_dat (out_if.out_dat_o),
        .rd_vld (out_if.out_vld_o),
        .rd_rdy (out_if.out_rdy_i)
    );
`else
    logic       hold_vld;
    logic [8:0] hold_dat;
    assign accept = ~hold_vld | out_if.out_rdy_i;
    assign out_if.out_vld_o = hold_vld;
    assign out_if.out_dat_o = hold_dat;
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
        end else if (good && accept) begin
            hold_vld <= 1'b1;
            hold_dat <= word;
        end else if (out_if.out_rdy_i) begin
            hold_vld <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_prmcu_uart_rx.sv
// tb_prmcu_uart_rx: directed frames with a word scoreboard and error-pulse counters.
`timescale 1ns/1ps
module tb_prmcu_uart_rx;
    import prmcu_uart_pkg::*;
    localparam int BIT = 87;
    logic       clk = 1'b0, rst = 1'b1, uart_en = 1'b1, rx_en = 1'b1, n_parity_bits = 1'b0, rx_i = 1'b1;
    logic [1:0] n_stop_bits = 2'd1;
    logic [3:0] n_data_bits = 4'd8;
    logic [7:0] internal_clk_divider = 8'd87;
    logic       parity_err_o, frame_err_o, overrun_o;
    int         n_cmp = 0, n_bad = 0;
    int         pe_cnt = 0, fe_cnt = 0, ov_cnt = 0, e_pe = 0, e_fe = 0, e_ov = 0;
    logic [8:0] exp_q[$];
    prmcu_uart_rx_if u_if ();
    prmcu_uart_rx #(.DIV_W(8), .FIFO_DEPTH(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .uart_en              (uart_en),
        .rx_en                (rx_en),
        .n_parity_bits        (n_parity_bits),
        .n_stop_bits          (n_stop_bits),
        .n_data_bits          (n_data_bits),
        .internal_clk_divider (internal_clk_divider),
        .rx_i                 (rx_i),
        .out_if               (u_if.master),
        .parity_err_o         (parity_err_o),
        .frame_err_o          (frame_err_o),
        .overrun_o            (overrun_o)
    );
    always #50 clk = ~clk;
    always @(negedge clk) begin
        pe_cnt += int'(parity_err_o);
        fe_cnt += int'(frame_err_o);
        ov_cnt += int'(overrun_o);
        if (u_if.out_vld_o && u_if.out_rdy_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_word: got 0x%03h, none expected", u_if.out_dat_o);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if (u_if.out_dat_o !== e) begin
                    n_bad++;
                    $display("FAIL out_word: got 0x%03h, expected 0x%03h", u_if.out_dat_o, e);
                end
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic check_flags(input string name);
        check({name, "_parity"}, pe_cnt, e_pe);
        check({name, "_frame"}, fe_cnt, e_fe);
        check({name, "_overrun"}, ov_cnt, e_ov);
    endtask
    task automatic bit_out(input logic v);
        rx_i = v;
        tick(BIT);
    endtask
    task automatic send(input logic [8:0] d, input bit pen, input bit pbit, input bit stop_v);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        if (pen) bit_out(pbit);
        bit_out(stop_v);
        rx_i = 1'b1;
    endtask
    initial begin
        int lat;
        u_if.out_rdy_i = 1'b1;
        tick(5);
        check("rst_vld", int'(u_if.out_vld_o), 0);
        check("rst_dat", int'(u_if.out_dat_o), 0);
        check("rst_pulses", int'({parity_err_o, frame_err_o, overrun_o}), 0);
        rst = 1'b0;
        tick(5);
        // Basic word plus start-edge to valid latency
        exp_q.push_back(9'h0A5);
        lat = 0;
        fork
            send(9'h0A5, 0, 0, 1);
            while (!u_if.out_vld_o && lat < 2000) begin
                tick(1);
                lat++;
            end
        join
        check("latency_820_840", int'(lat >= 820 && lat <= 840), 1);
        tick(2 * BIT);
        check_flags("word_a5");
        // Bad parity on 0x3C (even parity would be 0)
        n_parity_bits = 1'b1;
        send(9'h03C, 1, 1, 1);
        e_pe++;
        tick(2 * BIT);
        check_flags("parity");
        n_parity_bits = 1'b0;
        // Stop bit 0 then break for 20 bit times
        send(9'h000, 0, 0, 0);
        rx_i = 1'b0;
        tick(20 * BIT);
        rx_i = 1'b1;
        e_fe++;
        tick(3 * BIT);
        check_flags("break");
        // Short glitch rejected
        rx_i = 1'b0;
        tick(30);
        rx_i = 1'b1;
        tick(100);
        check("glitch_idle", int'(dut.state), int'(IDLE));
        check_flags("glitch");
        // Overrun with consumer stalled
        u_if.out_rdy_i = 1'b0;
`ifdef PRMCU_UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) begin
            if (i < 5) exp_q.push_back(9'(i));
            send(9'(i), 0, 0, 1);
            tick(BIT);
        end
        check("fifo_head", int'(u_if.out_dat_o), 1);
`else
        exp_q.push_back(9'h011);
        send(9'h011, 0, 0, 1);
        tick(BIT);
        send(9'h022, 0, 0, 1);
        tick(BIT);
        check("hold_dat", int'(u_if.out_dat_o), 'h11);
`endif
        e_ov++;
        check("hold_vld", int'(u_if.out_vld_o), 1);
        check_flags("overrun");
        u_if.out_rdy_i = 1'b1;
        tick(10);
        check("drained", exp_q.size(), 0);
        // Disable at data bit 3
        fork
            send(9'h05A, 0, 0, 1);
            begin
                tick(4 * BIT + BIT / 2);
                rx_en = 1'b0;
            end
        join
        tick(BIT);
        rx_en = 1'b1;
        tick(BIT);
        check_flags("disable");
        exp_q.push_back(9'h05A);
        send(9'h05A, 0, 0, 1);
        tick(2 * BIT);
        check("after_enable", exp_q.size(), 0);
        // Reset at data bit 3 with a word held
        u_if.out_rdy_i = 1'b0;
        send(9'h033, 0, 0, 1);
        tick(BIT);
        check("pre_rst_dat", int'(u_if.out_dat_o), 'h33);
        fork
            send(9'h05A, 0, 0, 1);
            begin
                tick(4 * BIT + BIT / 2);
                rst = 1'b1;
                tick(2);
                check("mid_rst_vld", int'(u_if.out_vld_o), 0);
                check("mid_rst_dat", int'(u_if.out_dat_o), 0);
            end
        join
        tick(BIT);
        rst = 1'b0;
        u_if.out_rdy_i = 1'b1;
        tick(BIT);
        check_flags("reset");
        exp_q.push_back(9'h05A);
        send(9'h05A, 0, 0, 1);
        tick(2 * BIT);
        check("after_reset", exp_q.size(), 0);
        check_flags("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
